// File: rtl/encostate_tx.sv
// -----------------------------------------------------------------------------
// encostate_tx
//   Re-encodes a decoded display index (0..8) into the 4-bit state code (1..9)
//   that the state-code decoder consumes, behind a valid/ready handshake with a
//   single-entry output register. Illegal indices (9..15) are consumed, flagged
//   with a one-cycle err pulse and counted in a saturating error counter.
//
//   Optional build macro: ENCOSTATE_AUTOSTEP_EN
//     When defined, an internal auto-stepper injects indices 0..8 (wrapping)
//     every DWELL cycles while auto_en=1 and no external index is offered.
//     When undefined, auto_en is ignored and no stepper logic is built.
//
// Parameters:
//   DEDUP  - 1: an accepted index whose code equals the last emitted code
//            produces no output beat
//   DWELL  - auto-step period in clk cycles (optional feature only)
//   ERRW   - width of the saturating error counter
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   idx_in     index to encode (legal 0..8)
//   in_valid   idx_in valid this cycle
//   in_ready   block can accept idx_in this cycle
//   code_out   encoded state code
//   out_valid  code_out holds an untaken beat
//   out_ready  downstream consumes code_out this cycle
//   err        one-cycle pulse after an accepted illegal index
//   err_cnt    saturating count of illegal indices
//   auto_en    auto-step enable (optional feature only)
// -----------------------------------------------------------------------------
module encostate_tx #(
    parameter int DEDUP = 0,
    parameter int DWELL = 50_000_000,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      idx_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3:0]      code_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    input  logic            auto_en
);

    localparam logic [0:0]      ST_EMPTY = 1'b0;
    localparam logic [0:0]      ST_FULL  = 1'b1;
    localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    // Exact inverse of the decoder's code->index map.
    function automatic logic [3:0] encode(input logic [3:0] idx);
        case (idx)
            4'd0:    encode = 4'd4;
            4'd1:    encode = 4'd5;
            4'd2:    encode = 4'd6;
            4'd3:    encode = 4'd3;
            4'd4:    encode = 4'd2;
            4'd5:    encode = 4'd1;
            4'd6:    encode = 4'd7;
            4'd7:    encode = 4'd8;
            4'd8:    encode = 4'd9;
            default: encode = 4'd0;
        endcase
    endfunction

    logic [0:0]      state_reg, state_next;
    logic [3:0]      code_reg, code_next;
    logic [3:0]      last_reg, last_next;
    logic            err_reg, err_next;
    logic [ERRW-1:0] err_cnt_reg, err_cnt_next;

    logic            eff_valid;
    logic [3:0]      eff_idx;
    logic            accept;
    logic            legal;
    logic            dup;
    logic            emit;
    logic [3:0]      new_code;

    // Held low during reset so nothing upstream believes a beat was taken.
    assign in_ready = !rst && ((state_reg == ST_EMPTY) || out_ready);

`ifdef ENCOSTATE_AUTOSTEP_EN
    localparam logic [CNTW-1:0] DWELL_TC = CNTW'(DWELL - 1);

    logic [CNTW-1:0] dwell_reg;
    logic [3:0]      auto_idx_reg;
    logic            auto_fire;

    // External traffic always wins; the stepper only fires into an idle input.
    assign auto_fire = auto_en && !in_valid && (dwell_reg == DWELL_TC) && in_ready;
    assign eff_valid = in_valid || auto_fire;
    assign eff_idx   = in_valid ? idx_in : auto_idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg    <= '0;
            auto_idx_reg <= 4'd0;
        end else if (!auto_en || in_valid) begin
            dwell_reg <= '0;
        end else if (dwell_reg == DWELL_TC) begin
            // Terminal count waits here until the output can take the beat.
            if (in_ready) begin
                dwell_reg    <= '0;
                auto_idx_reg <= (auto_idx_reg == 4'd8) ? 4'd0 : auto_idx_reg + 4'd1;
            end
        end else begin
            dwell_reg <= dwell_reg + CNTW'(1);
        end
    end
`else
    logic            unused_auto_en;
    logic [CNTW-1:0] unused_dwell_tc;

    assign unused_auto_en  = auto_en;
    assign unused_dwell_tc = CNTW'(DWELL - 1);
    assign eff_valid       = in_valid;
    assign eff_idx         = idx_in;
`endif

    assign accept   = eff_valid && in_ready;
    assign legal    = (eff_idx <= 4'd8);
    assign new_code = encode(eff_idx);
    // last_reg resets to 0, a code never produced, so the first beat always goes.
    assign dup      = (DEDUP != 0) && (new_code == last_reg);
    assign emit     = accept && legal && !dup;

    always_comb begin
        state_next   = state_reg;
        code_next    = code_reg;
        last_next    = last_reg;
        err_next     = accept && !legal;
        err_cnt_next = err_cnt_reg;

        if (err_next && (err_cnt_reg != ERR_MAX)) begin
            err_cnt_next = err_cnt_reg + ERRW'(1);
        end

        if (emit) begin
            state_next = ST_FULL;
            code_next  = new_code;
            last_next  = new_code;
        end else if ((state_reg == ST_FULL) && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_EMPTY;
            code_reg    <= 4'd0;
            last_reg    <= 4'd0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            last_reg    <= last_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign code_out  = code_reg;
    assign out_valid = (state_reg == ST_FULL);
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
